// File: rtl/data_mem_pkg.sv
// Shared types, widths and the address legality check for the data-memory responder.
package data_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Word-aligned and inside the DEPTH-word array.
  function automatic logic addr_ok(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < WORD_W'(4 * depth));
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 word storage: byte-enabled synchronous write, asynchronous read.
module mem_word_array
  import data_mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  windex,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rindex,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) mem_q[windex][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[rindex];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core data-memory port: one outstanding load/store, WAIT_CYCLES
// wait states before the access, response held until the core consumes it.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               ok_c;
  logic               access_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [WORD_W-1:0]  mem_rdata;

  // Ready must drop combinationally while reset is held low.
  assign req_ready = reset && (state_q == IDLE);

  assign ok_c     = addr_ok(req_q.addr, DEPTH);
  assign idx_c    = req_q.addr[IDX_W+1:2];
  assign access_c = reset && (state_q == WAIT) && (cnt_q == '0);
  assign mem_we_c = access_c && req_q.we && ok_c;

  mem_word_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .we     (mem_we_c),
    .be     (req_q.be),
    .windex (idx_c),
    .wdata  (req_q.wdata),
    .rindex (idx_c),
    .rdata  (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Load data is the pre-write array contents; stores and errors return zero.
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ok_c;
          rsp_rdata_d = (!req_q.we && ok_c) ? mem_rdata : '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with 2 wait states, one with none.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with rsp_ready high; lat = sampled cycles from accept to rsp_valid.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    check("xact_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin step(); lat++; end
    rdata = rsp_rdata;
    err   = rsp_err;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    rsp_ready0 = 1'b1;
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
    reset = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic store then load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st10_lat", 32'(lat), 32'd3);
    check("st10_rdata", rd, 32'd0);
    check("st10_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_lat", 32'(lat), 32'd3);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);

    // Byte-enable merge
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("be_merge", rd, 32'h11BB33DD);

    // be=0 store is a legal no-op
    xact(1'b1, 32'h10, 32'h55555555, 4'h0, rd, er, lat);
    check("be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("be0_unchanged", rd, 32'hDEADBEEF);

    // Misaligned load
    xact(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);

    // Out-of-range store must not alias onto word 0
    xact(1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat);
    xact(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("oor_word0", rd, 32'h01020304);
    check("oor_word0_err", 32'(er), 32'd0);

    // Last legal word
    xact(1'b1, 32'hFC, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    check("last_st_err", 32'(er), 32'd0);
    xact(1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat);
    check("last_ld", rd, 32'hA5A5A5A5);

    // Back-pressure with a second request held pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'h0;
    step();
    req_addr = 32'h10;
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    check("bp_lat", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'h11BB33DD);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_rel_valid", 32'(rsp_valid), 32'd0);
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    step();
    check("bp_second_acc", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    check("bp2_lat", 32'(n), 32'd3);
    check("bp2_rdata", rsp_rdata, 32'hDEADBEEF);
    step();

    // Reset one cycle after accept drops the pending store
    xact(1'b1, 32'h04, 32'h12345678, 4'hF, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    reset = 1'b0;
    step();
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rw_idle", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
    check("rw_word4", rd, 32'h12345678);

    // Reset landing exactly on the access edge
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rw0_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    #1;
    xact(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
    check("rw0_word4", rd, 32'h12345678);

    // Zero wait states: store then back-to-back loads, rsp_ready tied high
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'h0BADCAFE; req_be0 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      check("z_ready", 32'(req_ready0), 32'd1);
      step();
      req_we0 = 1'b0;
      check("z_wait", 32'(rsp_valid0), 32'd0);
      step();
      check("z_valid", 32'(rsp_valid0), 32'd1);
      check("z_rdata", rsp_rdata0, (k == 0) ? 32'd0 : 32'h0BADCAFE);
      check("z_err", 32'(rsp_err0), 32'd0);
      step();
    end
    req_valid0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the CPU data-memory port: accepts one load or store request at a time from the core over a valid/ready handshake, services it against a word-organised RAM after a programmable number of wait states, and returns a response over a second valid/ready handshake. It replaces the zero-latency data RAM behind the core's load/store path, so the core can run against realistic memory latency. Misaligned or out-of-range accesses are flagged rather than silently aliased.

## Interface
- DEPTH, 64, number of 32-bit words in the array (power of two, 4..1024)
- WAIT_CYCLES, 2, wait states inserted between request accept and access (0..15)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents a request
- req_ready  out  1  responder can accept; high only in IDLE and only while reset is high
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, byte lane i = bits 8i+7:8i
- req_be  in  4  store byte enables; ignored for loads
- rsp_valid  out  1  response available
- rsp_ready  in  1  core consumes response
- rsp_rdata  out  32  load data; 0 for stores and for errored requests
- rsp_err  out  1  request was misaligned or out of range

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if req_valid && req_ready at an edge, latch we/addr/wdata/be, load cnt <= WAIT_CYCLES, go to WAIT.
- WAIT: if cnt != 0 then cnt <= cnt-1; else perform the access, register rsp_rdata/rsp_err, go to RESP.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err held stable; on rsp_valid && rsp_ready go to IDLE.
- Word index = addr[log2(DEPTH)+1:2].
- Error if addr[1:0] != 0 or addr >= 4*DEPTH. An errored store writes nothing; an errored load returns 0. rsp_err = 1 in both cases.
- Store: write only the lanes with be[i] = 1. be = 4'b0000 is a legal no-op (no error). Stores return rdata = 0.
- Load: returns the full word, taken from the array contents before this access.
- Only one request is outstanding. Inputs that change during WAIT/RESP are ignored; the latched copy is used.
- The array is not cleared by reset; its contents after power-up are undefined.

## Timing
- Reset values: state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 during any cycle with reset low and 1 in the first cycle after.
- Accept at edge E. Access and response register at edge E+WAIT_CYCLES+1, so rsp_valid is high in the following cycle.
- The store becomes visible in the array at that same edge. Any later request observes it (read-after-write coherent).
- Response consumed at the first edge with rsp_ready high in RESP. The earliest next accept is the following edge. Minimum request period is WAIT_CYCLES+3 cycles.
- Back-pressure: rsp_valid stays high indefinitely until rsp_ready; req_ready stays 0 meanwhile.
- Reset mid-operation: reset wins at the edge. Any pending access in WAIT is discarded and no write occurs, even if cnt == 0 at that edge. A pending response is dropped.
- The core must hold the request payload stable while req_valid && !req_ready. The responder samples the payload only at the handshake.

## Structure
- Package data_mem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - WORD_W = 32 and BE_W = 4;
  - an addr_ok function (alignment and range check parameterised by DEPTH).
- Sub-module mem_word_array: DEPTH x 32 storage with byte-enabled synchronous write (we, be, windex, wdata) and asynchronous read (rindex -> rdata). The FSM, counter and error logic stay in data_mem_responder.

## Test plan
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with be=1111, then load 0x10. Required: rsp_valid rises 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
- Byte enables: store 0x11223344 to 0x20 (be=1111), then store 0xAABBCCDD with be=0101, then load 0x20. Required: rdata=0x11BB33DD.
- Errors: load 0x13 gives err=1, rdata=0. Store to 0x100 with DEPTH=64 gives err=1, and a following load of word 0 is unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid and rdata stable, req_ready=0; with a second req_valid held high, it is accepted only on the edge after rsp_ready goes high.
- Reset mid-WAIT: store 0xCAFEF00D to 0x04 (word 0x04 previously holds 0x12345678), assert reset one cycle after accept. Required: rsp_valid=0 next cycle, state IDLE, and a later load of 0x04 returns 0x12345678.
- WAIT_CYCLES=0: back-to-back loads with rsp_ready tied high. Required: rsp_valid 1 cycle after each accept, accepts spaced exactly 3 cycles apart.
